// File: rtl/rr_arb_pkg.sv
// Shared helpers for the round-robin arbitration tree and its response return path.
package rr_arb_pkg;

  // Reference configuration of the arbitration tree.
  localparam int DefNumOut    = 4;
  localparam int DefDataWidth = 32;
  localparam int DefDepth     = 4;

  // Ceiling log2, identical to $clog2 for positive arguments.
  function automatic int clog2_f(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return result;
  endfunction

  // Pointer width that never collapses to zero bits (Depth=1 still needs a 1-bit pointer).
  function automatic int ptr_width_f(input int depth);
    int w;
    w = clog2_f(depth);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  // Index and count types for the reference configuration.
  typedef logic [clog2_f(DefNumOut)-1:0]  idx_t;
  typedef logic [clog2_f(DefDepth+1)-1:0] cnt_t;

endpackage

// File: rtl/rr_idx_fifo.sv
// Ordering FIFO holding the winning requester index of every issued transaction.
// Depth need not be a power of two; pointers wrap explicitly at Depth-1.
module rr_idx_fifo
  import rr_arb_pkg::*;
#(
  parameter int Width    = 2,
  parameter int Depth    = 4,
  parameter int CntWidth = clog2_f(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                push_i,
  input  logic [Width-1:0]    data_i,
  input  logic                pop_i,
  output logic [Width-1:0]    head_o,
  output logic [CntWidth-1:0] count_o,
  output logic                full_o,
  output logic                empty_o
);

  localparam int                    PtrWidth = ptr_width_f(Depth);
  localparam logic [PtrWidth-1:0]   PtrLast  = PtrWidth'(Depth - 1);
  localparam logic [CntWidth-1:0]   CntFull  = CntWidth'(Depth);

  logic [Width-1:0]    mem_q [Depth];
  logic [Width-1:0]    mem_d [Depth];
  logic [PtrWidth-1:0] wr_ptr_q;
  logic [PtrWidth-1:0] wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q;
  logic [PtrWidth-1:0] rd_ptr_d;
  logic [CntWidth-1:0] count_q;
  logic [CntWidth-1:0] count_d;
  logic                push_s;
  logic                pop_s;

  // Wrapping increment for a pointer into a Depth-entry ring.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
    if (ptr == PtrLast) begin
      return {PtrWidth{1'b0}};
    end else begin
      return ptr + PtrWidth'(1);
    end
  endfunction

  assign full_o  = (count_q == CntFull);
  assign empty_o = (count_q == {CntWidth{1'b0}});
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Guard push/pop internally so the count can never leave 0..Depth.
  assign push_s = push_i & ~full_o;
  assign pop_s  = pop_i & ~empty_o;

  // Next-state for storage, pointers and occupancy; flush wins over push and pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = {PtrWidth{1'b0}};
      rd_ptr_d = {PtrWidth{1'b0}};
      count_d  = {CntWidth{1'b0}};
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CntWidth'(1);
        2'b01:   count_d = count_q - CntWidth'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset empties the ring and clears storage for deterministic heads.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= {Width{1'b0}};
      end
      wr_ptr_q <= {PtrWidth{1'b0}};
      rd_ptr_q <= {PtrWidth{1'b0}};
      count_q  <= {CntWidth{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rr_resp_router.sv
// Response return path of the round-robin arbitration tree: steers an in-order response
// stream back to the requester recorded at the head of the ordering FIFO.
module rr_resp_router
  import rr_arb_pkg::*;
#(
  parameter int NumOut    = DefNumOut,
  parameter int DataWidth = DefDataWidth,
  parameter int Depth     = DefDepth,
  parameter int IdxWidth  = clog2_f(NumOut),
  parameter int CntWidth  = clog2_f(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 issue_valid_i,
  input  logic [IdxWidth-1:0]  issue_idx_i,
  output logic                 issue_ready_o,
  input  logic                 resp_valid_i,
  output logic                 resp_ready_o,
  input  logic [DataWidth-1:0] resp_data_i,
  output logic [NumOut-1:0]    resp_valid_o,
  input  logic [NumOut-1:0]    resp_ready_i,
  output logic [DataWidth-1:0] resp_data_o,
  output logic [CntWidth-1:0]  outstanding_o,
  output logic                 err_unexp_o
);

  logic [IdxWidth-1:0] head_idx_s;
  logic [CntWidth-1:0] count_s;
  logic                full_s;
  logic                empty_s;
  logic                push_s;
  logic                pop_s;
  logic                head_ready_s;
  logic                err_unexp_q;
  logic                err_unexp_d;

  // issue_ready_o depends only on the registered count, never on the response side.
  assign issue_ready_o = ~full_s;
  assign push_s        = issue_valid_i & issue_ready_o;
  assign pop_s         = resp_valid_i & resp_ready_o;
  assign outstanding_o = count_s;
  assign resp_data_o   = resp_data_i;
  assign err_unexp_o   = err_unexp_q;

  rr_idx_fifo #(
    .Width    (IdxWidth),
    .Depth    (Depth),
    .CntWidth (CntWidth)
  ) u_idx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push_s),
    .data_i  (issue_idx_i),
    .pop_i   (pop_s),
    .head_o  (head_idx_s),
    .count_o (count_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Decode the head index: one-hot valid to the owner, and pick up only the owner's ready.
  always_comb begin
    resp_valid_o = {NumOut{1'b0}};
    head_ready_s = 1'b0;
    for (int i = 0; i < NumOut; i++) begin
      if (head_idx_s == IdxWidth'(i)) begin
        resp_valid_o[i] = resp_valid_i & ~empty_s;
        head_ready_s    = resp_ready_i[i];
      end else begin
        resp_valid_o[i] = 1'b0;
      end
    end
  end

  // A response with nothing outstanding is held back (no ready) rather than dropped.
  assign resp_ready_o = ~empty_s & head_ready_s;

  // Sticky unexpected-response flag, cleared only by flush or reset.
  always_comb begin
    if (flush_i) begin
      err_unexp_d = 1'b0;
    end else begin
      err_unexp_d = err_unexp_q | (resp_valid_i & empty_s);
    end
  end

  // Error flag register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_unexp_q <= 1'b0;
    end else begin
      err_unexp_q <= err_unexp_d;
    end
  end

endmodule

// File: tb/tb_rr_resp_router.sv
// Directed bench for rr_resp_router (NumOut=4, DataWidth=32, Depth=4).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_rr_resp_router;

  logic        clk_i;
  logic        rst_i;
  logic        flush_i;
  logic        issue_valid_i;
  logic [1:0]  issue_idx_i;
  logic        issue_ready_o;
  logic        resp_valid_i;
  logic        resp_ready_o;
  logic [31:0] resp_data_i;
  logic [3:0]  resp_valid_o;
  logic [3:0]  resp_ready_i;
  logic [31:0] resp_data_o;
  logic [2:0]  outstanding_o;
  logic        err_unexp_o;

  int vectors;
  int miscompares;

  rr_resp_router #(.NumOut(4), .DataWidth(32), .Depth(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_idx_i(issue_idx_i), .issue_ready_o(issue_ready_o),
    .resp_valid_i(resp_valid_i), .resp_ready_o(resp_ready_o), .resp_data_i(resp_data_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_data_o(resp_data_o),
    .outstanding_o(outstanding_o), .err_unexp_o(err_unexp_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic do_issue(input logic [1:0] idx);
    issue_valid_i = 1'b1;
    issue_idx_i   = idx;
    tick();
    issue_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; resp_valid_i = 1'b1; resp_data_i = 32'hCAFE_0001;
    #1;
    vectors++; if (outstanding_o !== 3'd0) begin miscompares++; $display("FAIL reset_outstanding got %0d exp 0", outstanding_o); end
    vectors++; if (issue_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_issue_ready got %b exp 1", issue_ready_o); end
    vectors++; if (resp_valid_o !== 4'b0000 || resp_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_resp got %b/%b exp 0000/0", resp_valid_o, resp_ready_o); end
    vectors++; if (resp_data_o !== 32'hCAFE_0001) begin miscompares++; $display("FAIL reset_data got %h exp cafe0001", resp_data_o); end
    vectors++; if (err_unexp_o !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", err_unexp_o); end
    resp_valid_i = 1'b0;
    tick(); rst_i = 1'b0;
    do_issue(2'd1); do_issue(2'd2); do_issue(2'd3);
    #1;
    vectors++; if (outstanding_o !== 3'd3) begin miscompares++; $display("FAIL prereset_outstanding got %0d exp 3", outstanding_o); end
    resp_valid_i = 1'b1; resp_ready_i = 4'b0000;
    #2 rst_i = 1'b1;
    #1;
    vectors++; if (outstanding_o !== 3'd0 || issue_ready_o !== 1'b1) begin miscompares++; $display("FAIL midreset got out=%0d rdy=%b exp 0/1", outstanding_o, issue_ready_o); end
    vectors++; if (resp_valid_o !== 4'b0000) begin miscompares++; $display("FAIL midreset_valid got %b exp 0000", resp_valid_o); end
    resp_valid_i = 1'b0;
    tick(); rst_i = 1'b0; resp_ready_i = 4'b1111;
  endtask

  task automatic test_routing();
    logic [3:0]  exp_v [3];
    logic [31:0] exp_d [3];
    exp_v[0] = 4'b0100; exp_v[1] = 4'b0001; exp_v[2] = 4'b1000;
    exp_d[0] = 32'hD000_0000; exp_d[1] = 32'hD111_1111; exp_d[2] = 32'hD222_2222;
    do_issue(2'd2); do_issue(2'd0); do_issue(2'd3);
    #1;
    vectors++; if (outstanding_o !== 3'd3) begin miscompares++; $display("FAIL route_out3 got %0d exp 3", outstanding_o); end
    resp_ready_i = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      resp_valid_i = 1'b1; resp_data_i = exp_d[k];
      #1;
      vectors++; if (resp_valid_o !== exp_v[k] || resp_data_o !== exp_d[k] || resp_ready_o !== 1'b1) begin
        miscompares++; $display("FAIL route_%0d got %b/%h/%b exp %b/%h/1", k, resp_valid_o, resp_data_o, resp_ready_o, exp_v[k], exp_d[k]);
      end
    end
    tick(); resp_valid_i = 1'b0;
    #1;
    vectors++; if (outstanding_o !== 3'd0) begin miscompares++; $display("FAIL route_out0 got %0d exp 0", outstanding_o); end
  endtask

  task automatic test_full();
    logic [3:0] exp_v [4];
    exp_v[0] = 4'b0010; exp_v[1] = 4'b0100; exp_v[2] = 4'b1000; exp_v[3] = 4'b0100;
    tick();
    do_issue(2'd0); do_issue(2'd1); do_issue(2'd2); do_issue(2'd3);
    issue_valid_i = 1'b1; issue_idx_i = 2'd1;
    #1;
    vectors++; if (issue_ready_o !== 1'b0 || outstanding_o !== 3'd4) begin miscompares++; $display("FAIL full_ready got %b/%0d exp 0/4", issue_ready_o, outstanding_o); end
    tick();
    issue_idx_i = 2'd2; resp_valid_i = 1'b1; resp_ready_i = 4'b1111;
    #1;
    vectors++; if (issue_ready_o !== 1'b0 || resp_valid_o !== 4'b0001) begin miscompares++; $display("FAIL full_poppush got %b/%b exp 0/0001", issue_ready_o, resp_valid_o); end
    tick();
    resp_valid_i = 1'b0;
    #1;
    vectors++; if (issue_ready_o !== 1'b1 || outstanding_o !== 3'd3) begin miscompares++; $display("FAIL full_after_pop got %b/%0d exp 1/3", issue_ready_o, outstanding_o); end
    tick();
    issue_valid_i = 1'b0;
    #1;
    vectors++; if (outstanding_o !== 3'd4) begin miscompares++; $display("FAIL full_refill got %0d exp 4", outstanding_o); end
    resp_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++; if (resp_valid_o !== exp_v[k]) begin miscompares++; $display("FAIL full_drain_%0d got %b exp %b", k, resp_valid_o, exp_v[k]); end
      tick();
    end
    resp_valid_i = 1'b0;
    #1;
    vectors++; if (outstanding_o !== 3'd0) begin miscompares++; $display("FAIL full_empty got %0d exp 0", outstanding_o); end
  endtask

  task automatic test_backpressure();
    tick();
    do_issue(2'd1); do_issue(2'd3);
    resp_valid_i = 1'b1; resp_ready_i = 4'b1101;
    #1;
    vectors++; if (resp_valid_o !== 4'b0010 || resp_ready_o !== 1'b0) begin miscompares++; $display("FAIL bp_hold got %b/%b exp 0010/0", resp_valid_o, resp_ready_o); end
    tick();
    #1;
    vectors++; if (outstanding_o !== 3'd2) begin miscompares++; $display("FAIL bp_nopop got %0d exp 2", outstanding_o); end
    resp_ready_i = 4'b1111;
    #1;
    vectors++; if (resp_ready_o !== 1'b1) begin miscompares++; $display("FAIL bp_release got %b exp 1", resp_ready_o); end
    tick();
    #1;
    vectors++; if (resp_valid_o !== 4'b1000 || outstanding_o !== 3'd1) begin miscompares++; $display("FAIL bp_next got %b/%0d exp 1000/1", resp_valid_o, outstanding_o); end
    tick();
    resp_valid_i = 1'b0;
  endtask

  task automatic test_unexpected();
    tick();
    resp_valid_i = 1'b1; resp_ready_i = 4'b1111; issue_valid_i = 1'b1; issue_idx_i = 2'd3;
    #1;
    vectors++; if (resp_ready_o !== 1'b0 || resp_valid_o !== 4'b0000) begin miscompares++; $display("FAIL unexp_hold got %b/%b exp 0/0000", resp_ready_o, resp_valid_o); end
    tick();
    issue_valid_i = 1'b0;
    #1;
    vectors++; if (err_unexp_o !== 1'b1) begin miscompares++; $display("FAIL unexp_err got %b exp 1", err_unexp_o); end
    vectors++; if (resp_valid_o !== 4'b1000 || resp_ready_o !== 1'b1) begin miscompares++; $display("FAIL unexp_route got %b/%b exp 1000/1", resp_valid_o, resp_ready_o); end
    tick();
    resp_valid_i = 1'b0;
    #1;
    vectors++; if (err_unexp_o !== 1'b1 || outstanding_o !== 3'd0) begin miscompares++; $display("FAIL unexp_sticky got %b/%0d exp 1/0", err_unexp_o, outstanding_o); end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    vectors++; if (err_unexp_o !== 1'b0) begin miscompares++; $display("FAIL unexp_clear got %b exp 0", err_unexp_o); end
  endtask

  task automatic test_flush();
    tick();
    resp_valid_i = 1'b1;
    tick();
    resp_valid_i = 1'b0;
    do_issue(2'd0); do_issue(2'd1);
    #1;
    vectors++; if (outstanding_o !== 3'd2 || err_unexp_o !== 1'b1) begin miscompares++; $display("FAIL flush_pre got %0d/%b exp 2/1", outstanding_o, err_unexp_o); end
    flush_i = 1'b1; issue_valid_i = 1'b1; issue_idx_i = 2'd2; resp_valid_i = 1'b1; resp_ready_i = 4'b1111;
    tick();
    flush_i = 1'b0; issue_valid_i = 1'b0; resp_valid_i = 1'b0;
    #1;
    vectors++; if (outstanding_o !== 3'd0 || err_unexp_o !== 1'b0 || issue_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL flush_post got %0d/%b/%b exp 0/0/1", outstanding_o, err_unexp_o, issue_ready_o);
    end
    tick();
    do_issue(2'd2);
    resp_valid_i = 1'b1;
    #1;
    vectors++; if (resp_valid_o !== 4'b0100 || outstanding_o !== 3'd1) begin miscompares++; $display("FAIL flush_reuse got %b/%0d exp 0100/1", resp_valid_o, outstanding_o); end
    tick();
    resp_valid_i = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_i = 1'b1; flush_i = 1'b0; issue_valid_i = 1'b0; issue_idx_i = 2'd0;
    resp_valid_i = 1'b0; resp_data_i = 32'h0; resp_ready_i = 4'b1111;
    tick();
    test_reset();
    test_routing();
    test_full();
    test_backpressure();
    test_unexpected();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
